dmem_arbiter: RTL

- Round-robin arbiter that shares the single-port data memory (12-bit address, 17-bit bus write data, 12-bit read data, 1-cycle registered read) between NUM_CORES matrix-multiply cores.
- Sits between the core load/store ports and the memory. Serialises requests, drives the memory write/address/data pins, and returns read data to the core that issued the read.
- Replaces the direct core-to-memory connection used in the single-core build.

---
 rtl/dmem_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Round-robin arbiter sharing one single-port data memory
//            (1-cycle registered read) between NUM_CORES requesting cores.
//            Issues at most one grant every two cycles. Read data returns
//            two cycles after the grant with a one-hot rvalid.
// Options  : DMEM_ARB_LOCK_EN - adds a per-core lock input. A core granted
//            with its lock bit set keeps exclusive ownership of the memory
//            until it drops lock (atomic read-modify-write).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 12,
  parameter int DIN_W     = 17,
  parameter int DOUT_W    = 12
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CORES-1:0]          req,
  input  logic [NUM_CORES-1:0]          we,
  input  logic [NUM_CORES*ADDR_W-1:0]   addr,
  input  logic [NUM_CORES*DIN_W-1:0]    wdata,
`ifdef DMEM_ARB_LOCK_EN
  input  logic [NUM_CORES-1:0]          lock,
`endif
  output logic [NUM_CORES-1:0]          gnt,
  output logic [NUM_CORES-1:0]          rvalid,
  output logic [DOUT_W-1:0]             rdata,
  output logic                          mem_write_en,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DIN_W-1:0]              mem_datain,
  input  logic [DOUT_W-1:0]             mem_dataout
);

  localparam int PTR_W = $clog2(NUM_CORES);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  state_t               r_state;
  logic [PTR_W-1:0]     r_ptr;

  // Read-pending pipe: stage 0 is live during the grant cycle, stage 1 during
  // the cycle the memory presents its read data.
  logic                 r_p0_vld;
  logic [PTR_W-1:0]     r_p0_idx;
  logic                 r_p1_vld;
  logic [PTR_W-1:0]     r_p1_idx;

  logic [NUM_CORES-1:0] w_elig;
  logic                 w_found;
  logic [PTR_W-1:0]     w_win;
  logic [PTR_W-1:0]     w_ptr_next;
  logic [NUM_CORES-1:0] w_win_onehot;
  logic                 w_win_we;
  logic [ADDR_W-1:0]    w_win_addr;
  logic [DIN_W-1:0]     w_win_wdata;

  logic [ADDR_W-1:0]    w_addr_arr  [NUM_CORES];
  logic [DIN_W-1:0]     w_wdata_arr [NUM_CORES];

  // (base + off) modulo NUM_CORES, for the rotating search and pointer update
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input int off);
    int s;
    s = (int'(base) + off) % NUM_CORES;
    return PTR_W'(s);
  endfunction

  genvar g;
  generate
    for (g = 0; g < NUM_CORES; g++) begin : g_unpack
      assign w_addr_arr[g]  = addr[g*ADDR_W +: ADDR_W];
      assign w_wdata_arr[g] = wdata[g*DIN_W +: DIN_W];
    end
  endgenerate

`ifdef DMEM_ARB_LOCK_EN
  logic             r_locked;
  logic [PTR_W-1:0] r_owner;
  logic             w_lock_hold;

  // Ownership persists only while the owner keeps its lock bit raised
  assign w_lock_hold = r_locked & lock[r_owner];
  assign w_elig      = w_lock_hold ? (req & (NUM_CORES'(1) << r_owner)) : req;
`else
  assign w_elig      = req;
`endif

  // Rotating priority search: first eligible core at or above the pointer
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (w_elig[wrap_add(r_ptr, i)]) begin
        w_found = 1'b1;
        w_win   = wrap_add(r_ptr, i);
      end
    end
  end

  assign w_ptr_next   = wrap_add(w_win, 1);
  assign w_win_onehot = NUM_CORES'(1) << w_win;
  assign w_win_we     = we[w_win];
  assign w_win_addr   = w_addr_arr[w_win];
  assign w_win_wdata  = w_wdata_arr[w_win];

  // Arbitration FSM: grant and memory pins registered for exactly one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      gnt          <= '0;
      mem_write_en <= 1'b0;
      mem_addr     <= '0;
      mem_datain   <= '0;
`ifdef DMEM_ARB_LOCK_EN
      r_locked     <= 1'b0;
      r_owner      <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            gnt          <= w_win_onehot;
            mem_write_en <= w_win_we;
            mem_addr     <= w_win_addr;
            mem_datain   <= w_win_wdata;
            r_ptr        <= w_ptr_next;
            r_state      <= ST_ISSUE;
          end else begin
            gnt          <= '0;
            mem_write_en <= 1'b0;
          end
`ifdef DMEM_ARB_LOCK_EN
          if (w_found && lock[w_win]) begin
            r_locked <= 1'b1;
            r_owner  <= w_win;
          end else if (!w_lock_hold) begin
            r_locked <= 1'b0;
          end
`endif
        end
        ST_ISSUE: begin
          // req is deliberately ignored here so a core is never granted twice
          gnt          <= '0;
          mem_write_en <= 1'b0;
          r_state      <= ST_IDLE;
        end
        default: begin
          gnt          <= '0;
          mem_write_en <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  // Read return: carry winner two stages, capture memory data, pulse rvalid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p0_vld <= 1'b0;
      r_p0_idx <= '0;
      r_p1_vld <= 1'b0;
      r_p1_idx <= '0;
      rvalid   <= '0;
      rdata    <= '0;
    end else begin
      r_p0_vld <= (r_state == ST_IDLE) && w_found && !w_win_we;
      r_p0_idx <= w_win;
      r_p1_vld <= r_p0_vld;
      r_p1_idx <= r_p0_idx;
      if (r_p1_vld) begin
        rvalid <= NUM_CORES'(1) << r_p1_idx;
        rdata  <= mem_dataout;
      end else begin
        rvalid <= '0;
      end
    end
  end

endmodule

`default_nettype wire
